bus_mem_responder: RTL

Memory-side responder for the CPU's shared data bus: serves word reads, word writes and byte writes issued by the CPU on `BUS`/`Addr`/`Memread`/`Memwrite`. Also executes the DMA command (`Memwrite` = 2) as a background word-copy engine that raises a one-cycle interrupt into the CPU's `INTin`/`INTnum` inputs on completion. It is the only driver of `BUS` other than the CPU.

---
 rtl/bus_mem_responder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/bus_mem_responder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | bus_mem_responder: word/byte memory on the CPU shared bus plus a        |
// | background DMA word-copy engine with a one-cycle done interrupt.        |
// | Revision 1.0                                                            |
// +------------------------------------------------------------------------+
module bus_mem_responder #(
  parameter int          ADDR_W  = 10,
  parameter logic [31:0] IRQ_NUM = 32'd16
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [31:0] BUS,
  input  logic        Memread,
  input  logic [1:0]  Memwrite,
  input  logic [31:0] Addr,
  output logic        INTin,
  output logic [31:0] INTnum,
  output logic        dma_busy
);

  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [1:0] WR_NONE = 2'd0;
  localparam logic [1:0] WR_WORD = 2'd1;
  localparam logic [1:0] WR_DMA  = 2'd2;
  localparam logic [1:0] WR_BYTE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // Contents start at zero; reset deliberately leaves them alone.
  logic [31:0] mem [DEPTH] = '{default: 32'd0};

  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] src_cmd;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [15:0]       len;
  logic [15:0]       cnt;
  logic [4:0]        lane_lsb;
  logic              read_en;
  logic              cpu_access;
  logic              copy_en;
  logic              accept;
  logic              unused_addr;

  assign word_idx    = Addr[ADDR_W+1:2];
  assign lane_lsb    = {Addr[1:0], 3'b000};
  assign src_cmd     = ADDR_W'(BUS[31:16]);
  assign unused_addr = &{1'b0, Addr[31:ADDR_W+2]};

  // Drive enable depends only on the request lines, so turnaround is clean.
  assign read_en    = Memread && (Memwrite == WR_NONE);
  assign cpu_access = Memread || (Memwrite != WR_NONE);
  assign BUS        = read_en ? mem[word_idx] : 32'bz;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    copy_en    = 1'b0;
    accept     = 1'b0;
    INTin      = 1'b0;
    INTnum     = 32'd0;
    dma_busy   = 1'b1;
    case (state)
      IDLE: begin
        dma_busy = 1'b0;
        if (Memwrite == WR_DMA) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (len == 16'd0) begin
          state_next = DONE;
        end else if (!cpu_access) begin
          copy_en = 1'b1;
          if (({1'b0, cnt} + 17'd1) == {1'b0, len}) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        INTin      = 1'b1;
        INTnum     = IRQ_NUM;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= 16'd0;
    end else if (accept) begin
      dst <= word_idx;
      src <= src_cmd;
      len <= BUS[15:0];
      cnt <= 16'd0;
    end else if (copy_en) begin
      cnt <= cnt + 16'd1;
    end
  end

  // CPU writes and copy steps never share a cycle: copies only run when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (Memwrite == WR_WORD) begin
        mem[word_idx] <= BUS;
      end else if (Memwrite == WR_BYTE) begin
        mem[word_idx][lane_lsb +: 8] <= BUS[7:0];
      end else if (copy_en) begin
        mem[dst + ADDR_W'(cnt)] <= mem[src + ADDR_W'(cnt)];
      end
    end
  end

endmodule
`default_nettype wire
